adder_fu_ctrl: RTL and testbench

Sequencer for the tile's 4-lane adder functional unit. Holds a small local program of adder operations, issues each one to the FU (lane-split mode plus enable), waits for the FU completion acknowledge, latches the four lane results and delivers them to the neighbour port named by the program entry over a valid/ready handshake. It sits between the tile configuration loader (program writes, start) and the adder FU / tile output mux.

---
 rtl/adder_fu_ctrl_if.sv | 27 ++
 rtl/adder_fu_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_adder_fu_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_fu_ctrl_if.sv
// adder_fu_ctrl_if: FU issue/acknowledge bus plus the result-delivery handshake of the adder sequencer.
// Latency: none, signals only.
// Backpressure: out_valid/out_ready toward the neighbour port; fu_on_off/fu_ack toward the adder FU.
interface adder_fu_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [15:0]        fu_config;
  logic               fu_on_off;
  logic               fu_ack;
  logic [4*WIDTH-1:0] fu_outputs;
  logic [4*WIDTH-1:0] out_data;
  logic [1:0]         out_dest;
  logic               out_valid;
  logic               out_ready;

  // Sequencer side: drives the FU and the result port.
  modport master (
    output fu_config, fu_on_off, out_data, out_dest, out_valid,
    input  fu_ack, fu_outputs, out_ready
  );

  // FU / neighbour side.
  modport slave (
    input  fu_config, fu_on_off, out_data, out_dest, out_valid,
    output fu_ack, fu_outputs, out_ready
  );
endinterface

// File: rtl/adder_fu_ctrl.sv
// adder_fu_ctrl: runs a local program of adder ops on the 4-lane FU and forwards each result to a neighbour.
// Latency: start -> fu_on_off after 3 cycles; fu_ack -> out_valid next cycle; next fetch the cycle after handshake.
// Backpressure: result held on out_data/out_dest with out_valid until out_ready; ADDER_CTRL_TIMEOUT_EN bounds the fu_ack wait.
module adder_fu_ctrl #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [7:0]               cfg_wdata,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  adder_fu_ctrl_if.master          bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_SEND, S_ERR
  } state_t;

  state_t             state_q, state_nxt;
  logic [AW-1:0]      pc_q, pc_nxt;
  logic [1:0]         mode_q, mode_nxt;
  logic [1:0]         dest_q, dest_nxt;
  logic               last_q, last_nxt;
  logic [1:0]         fu_mode_q, fu_mode_nxt;
  logic               fu_on_q, fu_on_nxt;
  logic [4*WIDTH-1:0] data_q, data_nxt;
  logic [1:0]         odest_q, odest_nxt;
  logic               valid_q, valid_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic               err_q, err_nxt;
  logic [4:0]         entry;

  // Program entries keep only mode/dest/last; the reserved bits are dropped on write.
  logic [4:0]         prog_mem [DEPTH];
  logic               unused_cfg_bits;
  assign unused_cfg_bits = ^cfg_wdata[7:5];

`ifdef ADDER_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]      cnt_q, cnt_nxt;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // Program store: writable only while no program is running, survives reset.
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == S_IDLE || state_q == S_ERR))
      prog_mem[cfg_addr] <= cfg_wdata[4:0];
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_nxt   = state_q;
    pc_nxt      = pc_q;
    mode_nxt    = mode_q;
    dest_nxt    = dest_q;
    last_nxt    = last_q;
    fu_mode_nxt = fu_mode_q;
    fu_on_nxt   = fu_on_q;
    data_nxt    = data_q;
    odest_nxt   = odest_q;
    valid_nxt   = valid_q;
    done_nxt    = 1'b0;
    err_nxt     = err_q;
    entry       = prog_mem[pc_q];
`ifdef ADDER_CTRL_TIMEOUT_EN
    cnt_nxt     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
        end
      end
      S_FETCH: begin
        mode_nxt = entry[1:0];
        dest_nxt = entry[3:2];
        last_nxt = entry[4];
        if (entry[1:0] == 2'd2) begin
          state_nxt = S_ERR;
          err_nxt   = 1'b1;
          fu_on_nxt = 1'b0;
          valid_nxt = 1'b0;
        end else begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        fu_mode_nxt = mode_q;
        fu_on_nxt   = 1'b1;
        state_nxt   = S_WAIT;
`ifdef ADDER_CTRL_TIMEOUT_EN
        cnt_nxt     = '0;
`endif
      end
      S_WAIT: begin
        // An ack in the same cycle as the timeout still wins.
        if (bus.fu_ack) begin
          data_nxt  = bus.fu_outputs;
          odest_nxt = dest_q;
          fu_on_nxt = 1'b0;
          valid_nxt = 1'b1;
          state_nxt = S_SEND;
        end
`ifdef ADDER_CTRL_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          fu_on_nxt = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = S_ERR;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
`endif
      end
      S_SEND: begin
        if (bus.out_ready) begin
          valid_nxt = 1'b0;
          // The program ends at the final entry even without a last flag; pc never wraps.
          if (last_q || pc_q == AW'(DEPTH - 1)) begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            pc_nxt    = pc_q + AW'(1);
            state_nxt = S_FETCH;
          end
        end
      end
      S_ERR: begin
        if (start) begin
          err_nxt   = 1'b0;
          pc_nxt    = '0;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_ERR);
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      mode_q    <= '0;
      dest_q    <= '0;
      last_q    <= 1'b0;
      fu_mode_q <= '0;
      fu_on_q   <= 1'b0;
      data_q    <= '0;
      odest_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef ADDER_CTRL_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_nxt;
      pc_q      <= pc_nxt;
      mode_q    <= mode_nxt;
      dest_q    <= dest_nxt;
      last_q    <= last_nxt;
      fu_mode_q <= fu_mode_nxt;
      fu_on_q   <= fu_on_nxt;
      data_q    <= data_nxt;
      odest_q   <= odest_nxt;
      valid_q   <= valid_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
`ifdef ADDER_CTRL_TIMEOUT_EN
      cnt_q     <= cnt_nxt;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign bus.fu_config = {14'b0, fu_mode_q};
  assign bus.fu_on_off = fu_on_q;
  assign bus.out_data  = data_q;
  assign bus.out_dest  = odest_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_adder_fu_ctrl.sv
// tb_adder_fu_ctrl: directed program runs with a randomized FU model and scoreboard for adder_fu_ctrl.
// Latency: checks start->issue and ack->valid timing, done pulse width, timeout when ADDER_CTRL_TIMEOUT_EN.
// Backpressure: out_ready held low for several cycles while result stability is checked.
module tb_adder_fu_ctrl;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       start;
  logic       busy, done, err;

  adder_fu_ctrl_if #(.WIDTH(WIDTH)) bus ();

  adder_fu_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .busy(busy), .done(done),
    .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  mode;
    logic [63:0] a;
    logic [63:0] b;
  } fu_rec_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [4:0]  shadow [DEPTH];
  fu_rec_t     fu_q [$];
  bit          fu_en = 1'b1;
  int          fu_lat_max = 3;
  bit          use_dir = 1'b0;
  logic [63:0] dir_a, dir_b;
  bit          inject = 1'b0;

  // Reference adder: lane-split sums by mode, written as plain arithmetic.
  function automatic logic [63:0] fu_sum(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    r = '0;
    case (m)
      2'd0: for (int i = 0; i < 4; i++) r[16*i +: 16] = a[16*i +: 16] + b[16*i +: 16];
      2'd1: for (int i = 0; i < 2; i++) r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
      default: r = a + b;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // FU model: after a random latency while enabled, pulses ack with lane sums of random operands.
  initial begin
    bit     sent = 1'b0;
    int     lat  = 0;
    fu_rec_t rec;
    bus.fu_ack     = 1'b0;
    bus.fu_outputs = '0;
    forever begin
      @(negedge clk);
      bus.fu_ack = 1'b0;
      if (fu_en && bus.fu_on_off === 1'b1 && !sent) begin
        if (lat == 0) begin
          rec.mode = bus.fu_config[1:0];
          rec.a    = use_dir ? dir_a : {$urandom, $urandom};
          rec.b    = use_dir ? dir_b : {$urandom, $urandom};
          bus.fu_outputs = fu_sum(rec.mode, rec.a, rec.b);
          bus.fu_ack     = 1'b1;
          fu_q.push_back(rec);
          sent = 1'b1;
        end else begin
          lat--;
        end
      end
      if (bus.fu_on_off !== 1'b1) begin
        sent = 1'b0;
        lat  = $urandom_range(0, fu_lat_max);
      end
    end
  end

  task automatic prog_write(input int addr, input logic [4:0] e);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(addr);
    cfg_wdata = {3'($urandom_range(0, 7)), e};
    shadow[addr] = e;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_err_clear", 64'(err), 64'd0);
  endtask

  task automatic expect_delivery(input logic [1:0] mode, input logic [1:0] dest, input int hold, input bit is_last);
    fu_rec_t     rec;
    logic [63:0] exp_data;
    for (int i = 0; i < 60 && bus.out_valid !== 1'b1; i++) @(negedge clk);
    check("out_valid_seen", 64'(bus.out_valid), 64'd1);
    check("fu_rec_present", 64'(fu_q.size() != 0), 64'd1);
    rec = (fu_q.size() != 0) ? fu_q.pop_front() : '0;
    exp_data = fu_sum(mode, rec.a, rec.b);
    check("fu_config_mode", 64'(rec.mode), 64'(mode));
    check("out_data", bus.out_data, exp_data);
    check("out_dest", 64'(bus.out_dest), 64'(dest));
    check("fu_off_in_send", 64'(bus.fu_on_off), 64'd0);
    for (int i = 0; i < hold; i++) begin
      bus.out_ready = 1'b0;
      if (inject) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = 8'h02;
      end
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0; inject = 1'b0;
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_data", bus.out_data, exp_data);
      check("hold_dest", 64'(bus.out_dest), 64'(dest));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("valid_drop", 64'(bus.out_valid), 64'd0);
    check("done_pulse", 64'(done), 64'(is_last));
    if (is_last) begin
      check("end_busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
    end
  endtask

  task automatic expect_err();
    for (int i = 0; i < 20 && err !== 1'b1; i++) @(negedge clk);
    check("err_set", 64'(err), 64'd1);
    check("err_busy", 64'(busy), 64'd0);
    check("err_fu_off", 64'(bus.fu_on_off), 64'd0);
    check("err_valid", 64'(bus.out_valid), 64'd0);
  endtask

  // Walks the shadow program the way the sequencer should and checks each step.
  task automatic run_prog(input int hold);
    int         pc;
    bit         fin;
    logic [4:0] e;
    pulse_start();
    pc  = 0;
    fin = 1'b0;
    while (!fin) begin
      e = shadow[pc];
      if (e[1:0] == 2'd2) begin
        expect_err();
        fin = 1'b1;
      end else begin
        fin = e[4] || (pc == DEPTH - 1);
        expect_delivery(e[1:0], e[3:2], hold, fin);
        pc++;
      end
    end
  endtask

  initial begin
    logic [1:0] m;
    reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_fu_config", 64'(bus.fu_config), 64'd0);
    check("rst_fu_on_off", 64'(bus.fu_on_off), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_dest", 64'(bus.out_dest), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    reset = 1'b1;

    // Single entry, mode 0, dest E, last; fixed operands and zero FU latency.
    prog_write(0, 5'b1_01_00);
    fu_lat_max = 0;
    use_dir = 1'b1;
    dir_a = {16'd7, 16'd5, 16'd3, 16'd1};
    dir_b = {16'd8, 16'd6, 16'd4, 16'd2};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_fetch_busy", 64'(busy), 64'd1);
    check("t1_fetch_fu_off", 64'(bus.fu_on_off), 64'd0);
    @(negedge clk);
    check("t1_issue_fu_off", 64'(bus.fu_on_off), 64'd0);
    @(negedge clk);
    check("t1_wait_fu_on", 64'(bus.fu_on_off), 64'd1);
    check("t1_wait_config", 64'(bus.fu_config), 64'd0);
    @(negedge clk);
    check("t1_ack_to_valid", 64'(bus.out_valid), 64'd1);
    check("t1_lanes", bus.out_data, 64'h000f_000b_0007_0003);
    expect_delivery(2'd0, 2'd1, 0, 1'b1);
    use_dir = 1'b0;
    fu_lat_max = 3;

    // Modes 0,1,3 with backpressure in every SEND.
    prog_write(0, 5'b0_00_00);
    prog_write(1, 5'b0_10_01);
    prog_write(2, 5'b1_11_11);
    run_prog(5);

    // Illegal mode on entry 1, rerun from entry 0, then repair the entry while in ERR.
    prog_write(1, 5'b0_01_10);
    run_prog(0);
    run_prog(1);
    prog_write(1, 5'b1_01_01);
    check("err_kept_after_write", 64'(err), 64'd1);
    run_prog(0);

    // Reset during SEND; program store survives.
    prog_write(2, 5'b0_11_11);
    prog_write(1, 5'b0_01_01);
    prog_write(2, 5'b1_11_11);
    pulse_start();
    for (int i = 0; i < 60 && bus.out_valid !== 1'b1; i++) @(negedge clk);
    check("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b0;
    #1;
    check("async_valid", 64'(bus.out_valid), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_fu_off", 64'(bus.fu_on_off), 64'd0);
    check("async_data", bus.out_data, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    fu_q.delete();
    run_prog(0);

    // Eight entries without last; start/cfg_we pulsed while busy must be ignored.
    for (int i = 0; i < DEPTH; i++) begin
      m = 2'($urandom_range(0, 2));
      if (m == 2'd2) m = 2'd3;
      prog_write(i, {1'b0, 2'($urandom_range(0, 3)), m});
    end
    inject = 1'b1;
    run_prog(2);
    run_prog(0);

    // FU never acknowledges.
    prog_write(0, 5'b1_00_00);
    fu_en = 1'b0;
    pulse_start();
`ifdef ADDER_CTRL_TIMEOUT_EN
    repeat (16) @(negedge clk);
    check("to_not_yet", 64'(err), 64'd0);
    check("to_fu_on", 64'(bus.fu_on_off), 64'd1);
    @(negedge clk);
    check("to_err", 64'(err), 64'd1);
    check("to_fu_off", 64'(bus.fu_on_off), 64'd0);
    check("to_busy", 64'(busy), 64'd0);
    fu_en = 1'b1;
    run_prog(0);
`else
    repeat (100) @(negedge clk);
    check("nto_busy", 64'(busy), 64'd1);
    check("nto_err", 64'(err), 64'd0);
    check("nto_fu_on", 64'(bus.fu_on_off), 64'd1);
    fu_en = 1'b1;
    expect_delivery(2'd0, 2'd0, 0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
